// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV64I execute stage: immediate generation, ALU, branch/jump resolution, 1-deep output slot.
module execute_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [63:0] pc,
   input  logic [63:0] rs1_data,
   input  logic [63:0] rs2_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] alu_result,
   output logic [63:0] store_data,
   output logic [4:0]  rd,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic [2:0]  mem_funct3,
   output logic        branch_taken,
   output logic [63:0] branch_target,
   output logic        illegal
);
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, jalr_sum;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign imm_i    = {{52{instr[31]}}, instr[31:20]};
   assign imm_s    = {{52{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b    = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u    = {{32{instr[31]}}, instr[31:12], 12'd0};
   assign imm_j    = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign jalr_sum = rs1_data + imm_i;

   logic [63:0] alu_result_d, branch_target_d, op_b;
   logic [31:0] w_res;
   logic        reg_write_d, mem_read_d, mem_write_d, branch_taken_d, illegal_d;

   always_comb begin
      alu_result_d    = '0;
      branch_target_d = '0;
      reg_write_d     = 1'b0;
      mem_read_d      = 1'b0;
      mem_write_d     = 1'b0;
      branch_taken_d  = 1'b0;
      illegal_d       = 1'b0;
      w_res           = '0;
      op_b            = (opcode == OPC_OP || opcode == OPC_OP32) ? rs2_data : imm_i;
      case (opcode)
         OPC_OP, OPC_OPIMM: begin
            reg_write_d = 1'b1;
            case (funct3)
               3'b000: begin
                  if (opcode == OPC_OP && instr[30]) alu_result_d = rs1_data - op_b;
                  else                               alu_result_d = rs1_data + op_b;
               end
               3'b001: begin
                  alu_result_d = rs1_data << op_b[5:0];
                  if (opcode == OPC_OPIMM && instr[31:26] != 6'b000000) illegal_d = 1'b1;
               end
               3'b010:  alu_result_d = {63'd0, $signed(rs1_data) < $signed(op_b)};
               3'b011:  alu_result_d = {63'd0, rs1_data < op_b};
               3'b100:  alu_result_d = rs1_data ^ op_b;
               3'b101: begin
                  if (instr[30]) alu_result_d = $signed(rs1_data) >>> op_b[5:0];
                  else           alu_result_d = rs1_data >> op_b[5:0];
                  if (opcode == OPC_OPIMM && instr[31:26] != 6'b000000 && instr[31:26] != 6'b010000)
                     illegal_d = 1'b1;
               end
               3'b110:  alu_result_d = rs1_data | op_b;
               default: alu_result_d = rs1_data & op_b;
            endcase
         end
         OPC_OP32, OPC_OPIMM32: begin
            reg_write_d = 1'b1;
            case (funct3)
               3'b000: begin
                  if (opcode == OPC_OP32 && instr[30]) w_res = rs1_data[31:0] - op_b[31:0];
                  else                                 w_res = rs1_data[31:0] + op_b[31:0];
               end
               3'b001: w_res = rs1_data[31:0] << op_b[4:0];
               3'b101: begin
                  if (instr[30]) w_res = $signed(rs1_data[31:0]) >>> op_b[4:0];
                  else           w_res = rs1_data[31:0] >> op_b[4:0];
               end
               default: illegal_d = 1'b1;
            endcase
            alu_result_d = {{32{w_res[31]}}, w_res};
         end
         OPC_LUI: begin
            reg_write_d  = 1'b1;
            alu_result_d = imm_u;
         end
         OPC_AUIPC: begin
            reg_write_d  = 1'b1;
            alu_result_d = pc + imm_u;
         end
         OPC_JAL: begin
            reg_write_d     = 1'b1;
            branch_taken_d  = 1'b1;
            alu_result_d    = pc + 64'd4;
            branch_target_d = pc + imm_j;
         end
         OPC_JALR: begin
            reg_write_d     = 1'b1;
            branch_taken_d  = 1'b1;
            alu_result_d    = pc + 64'd4;
            branch_target_d = {jalr_sum[63:1], 1'b0};
         end
         OPC_BRANCH: begin
            branch_target_d = pc + imm_b;
            case (funct3)
               3'b000:  branch_taken_d = (rs1_data == rs2_data);
               3'b001:  branch_taken_d = (rs1_data != rs2_data);
               3'b100:  branch_taken_d = ($signed(rs1_data) <  $signed(rs2_data));
               3'b101:  branch_taken_d = ($signed(rs1_data) >= $signed(rs2_data));
               3'b110:  branch_taken_d = (rs1_data <  rs2_data);
               3'b111:  branch_taken_d = (rs1_data >= rs2_data);
               default: illegal_d = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            reg_write_d  = 1'b1;
            mem_read_d   = 1'b1;
            alu_result_d = rs1_data + imm_i;
         end
         OPC_STORE: begin
            mem_write_d  = 1'b1;
            alu_result_d = rs1_data + imm_s;
         end
         default: illegal_d = 1'b1;
      endcase
      // An illegal instruction must have no architectural side effects; x0 is never written.
      if (illegal_d) begin
         reg_write_d    = 1'b0;
         mem_read_d     = 1'b0;
         mem_write_d    = 1'b0;
         branch_taken_d = 1'b0;
      end
      if (instr[11:7] == 5'd0) reg_write_d = 1'b0;
   end

   logic        out_valid_q, reg_write_q, mem_read_q, mem_write_q, branch_taken_q, illegal_q;
   logic [63:0] alu_result_q, store_data_q, branch_target_q;
   logic [4:0]  rd_q;
   logic [2:0]  mem_funct3_q;
   logic        accept;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q     <= 1'b0;
         alu_result_q    <= '0;
         store_data_q    <= '0;
         branch_target_q <= '0;
         rd_q            <= '0;
         mem_funct3_q    <= '0;
         reg_write_q     <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         branch_taken_q  <= 1'b0;
         illegal_q       <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_valid_q     <= 1'b1;
         alu_result_q    <= alu_result_d;
         store_data_q    <= rs2_data;
         branch_target_q <= branch_target_d;
         rd_q            <= instr[11:7];
         mem_funct3_q    <= funct3;
         reg_write_q     <= reg_write_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         branch_taken_q  <= branch_taken_d;
         illegal_q       <= illegal_d;
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid     = out_valid_q;
   assign alu_result    = alu_result_q;
   assign store_data    = store_data_q;
   assign branch_target = branch_target_q;
   assign rd            = rd_q;
   assign mem_funct3    = mem_funct3_q;
   assign reg_write     = out_valid_q && reg_write_q;
   assign mem_read      = out_valid_q && mem_read_q;
   assign mem_write     = out_valid_q && mem_write_q;
   assign branch_taken  = out_valid_q && branch_taken_q;
   assign illegal       = out_valid_q && illegal_q;
endmodule
